// File: rtl/useq_pkg.sv
`default_nettype none
// =============================================================================
// useq_pkg : shared state, select encodings and microword layout for useq_controller
// Revision : 1.0
// =============================================================================
package useq_pkg;

    localparam int DEF_CTRL_W = 39;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_COND_W = 6;
    localparam int DEF_LOOP_W = 4;

    localparam logic [2:0] SEL_NONE  = 3'd0;
    localparam logic [2:0] SEL_LOOPZ = 3'd1;
    localparam logic [2:0] SEL_COND0 = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Packed MSB first, so ctrl lands in the least significant bits.
    typedef struct packed {
        logic                  end_run;
        logic                  dec_loop;
        logic                  ld_loop;
        logic                  pol;
        logic [2:0]            sel;
        logic [DEF_ADDR_W-1:0] tgt;
        logic [DEF_ADDR_W-1:0] next;
        logic [DEF_CTRL_W-1:0] ctrl;
    } uword_t;

endpackage
`default_nettype wire

// File: rtl/useq_branch_sel.sv
`default_nettype none
// =============================================================================
// useq_branch_sel : condition mux and taken / next micro-address resolution
// Revision : 1.0
// =============================================================================
module useq_branch_sel
    import useq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int COND_W = DEF_COND_W
) (
    input  logic [2:0]        sel,
    input  logic              pol,
    input  logic [COND_W-1:0] cond,
    input  logic              loop_zero,
    input  logic [ADDR_W-1:0] seq_addr,
    input  logic [ADDR_W-1:0] tgt_addr,
    output logic              taken,
    output logic [ADDR_W-1:0] next_addr
);

    logic cond_sel;

    // Select codes beyond the last condition input (or the 3-bit range) read as 0.
    always_comb begin
        cond_sel = 1'b0;
        if (sel == SEL_LOOPZ) begin
            cond_sel = loop_zero;
        end
        for (int i = 0; i < COND_W; i++) begin
            if ((i <= 5) && (sel == (3'(i) + SEL_COND0))) begin
                cond_sel = cond[i];
            end
        end
    end

    assign taken     = (sel != SEL_NONE) && (cond_sel ^ pol);
    assign next_addr = taken ? tgt_addr : seq_addr;

endmodule
`default_nettype wire

// File: rtl/useq_controller.sv
`default_nettype none
// =============================================================================
// useq_controller : microprogram sequencer with loop counter, abort and watchdog
// Revision : 1.0
// =============================================================================
module useq_controller
    import useq_pkg::*;
#(
    parameter int  CTRL_W    = DEF_CTRL_W,
    parameter int  ADDR_W    = DEF_ADDR_W,
    parameter int  COND_W    = DEF_COND_W,
    parameter int  LOOP_W    = DEF_LOOP_W,
    parameter int  LOOP_INIT = 7,
    parameter int  MAX_STEPS = 255,
    localparam int MW_W      = CTRL_W + 2 * ADDR_W + 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [MW_W-1:0]   rom_data_i,
    input  logic [COND_W-1:0] cond_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              ctrl_valid_o,
    output logic [ADDR_W-1:0] upc_o,
    output logic [LOOP_W-1:0] loop_cnt_o
);

    localparam int STEP_W   = $clog2(MAX_STEPS + 1);
    localparam int NEXT_LSB = CTRL_W;
    localparam int TGT_LSB  = CTRL_W + ADDR_W;
    localparam int SEL_LSB  = CTRL_W + 2 * ADDR_W;
    localparam int POL_BIT  = SEL_LSB + 3;
    localparam int LD_BIT   = POL_BIT + 1;
    localparam int DEC_BIT  = POL_BIT + 2;
    localparam int END_BIT  = POL_BIT + 3;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   upc;
    logic [ADDR_W-1:0]   rom_addr;
    logic [LOOP_W-1:0]   loop_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic                err;

    logic [CTRL_W-1:0]   mw_ctrl;
    logic [ADDR_W-1:0]   mw_next;
    logic [ADDR_W-1:0]   mw_tgt;
    logic [2:0]          mw_sel;
    logic                mw_pol;
    logic                mw_ld;
    logic                mw_dec;
    logic                mw_end;

    logic                loop_zero;
    logic                br_taken;
    logic [ADDR_W-1:0]   next_addr;
    logic [STEP_W-1:0]   step_next;
    logic                step_hit;
    logic                start_take;
    logic                exec_fire;

    assign mw_ctrl = rom_data_i[CTRL_W-1:0];
    assign mw_next = rom_data_i[NEXT_LSB +: ADDR_W];
    assign mw_tgt  = rom_data_i[TGT_LSB +: ADDR_W];
    assign mw_sel  = rom_data_i[SEL_LSB +: 3];
    assign mw_pol  = rom_data_i[POL_BIT];
    assign mw_ld   = rom_data_i[LD_BIT];
    assign mw_dec  = rom_data_i[DEC_BIT];
    assign mw_end  = rom_data_i[END_BIT];

    // Branch on the counter value held before this word's own load/decrement.
    assign loop_zero  = (loop_cnt == '0);
    assign step_next  = step_cnt + 1'b1;
    assign step_hit   = (step_next == STEP_W'(MAX_STEPS));
    assign start_take = (state == ST_IDLE) && start_i;
    assign exec_fire  = (state == ST_EXEC) && !abort_i;

    useq_branch_sel #(
        .ADDR_W (ADDR_W),
        .COND_W (COND_W)
    ) u_branch_sel (
        .sel       (mw_sel),
        .pol       (mw_pol),
        .cond      (cond_i),
        .loop_zero (loop_zero),
        .seq_addr  (mw_next),
        .tgt_addr  (mw_tgt),
        .taken     (br_taken),
        .next_addr (next_addr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_nxt = abort_i ? ST_DONE : ST_EXEC;
            end
            ST_EXEC: begin
                if (abort_i || mw_end || step_hit) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o       = 1'b0;
        done_o       = 1'b0;
        ctrl_valid_o = 1'b0;
        ctrl_o       = '0;
        case (state)
            ST_FETCH: begin
                busy_o = 1'b1;
            end
            ST_EXEC: begin
                busy_o       = 1'b1;
                ctrl_valid_o = !abort_i;
                ctrl_o       = abort_i ? '0 : mw_ctrl;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    // An aborted word is not executed: no PC, counter or step updates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            upc      <= '0;
            rom_addr <= '0;
            loop_cnt <= '0;
            step_cnt <= '0;
            err      <= 1'b0;
        end else if (start_take) begin
            upc      <= start_addr_i;
            rom_addr <= start_addr_i;
            step_cnt <= '0;
            err      <= 1'b0;
        end else if (exec_fire) begin
            upc      <= next_addr;
            rom_addr <= next_addr;
            step_cnt <= step_next;
            if (mw_ld) begin
                loop_cnt <= LOOP_W'(LOOP_INIT);
            end else if (mw_dec && !loop_zero) begin
                loop_cnt <= loop_cnt - 1'b1;
            end
            if (!mw_end && step_hit) begin
                err <= 1'b1;
            end
        end
    end

    assign err_o      = err;
    assign rom_addr_o = rom_addr;
    assign upc_o      = upc;
    assign loop_cnt_o = loop_cnt;

endmodule
`default_nettype wire
